// File: rtl/hcordic_pkg.sv
// Shared constants, state encoding and helpers for the CORDIC LUT sharing logic.
package hcordic_pkg;

  localparam logic [1:0] MODE_CIR = 2'b01;
  localparam logic [1:0] MODE_HYP = 2'b11;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lut_state_e;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_CIR) || (mode == MODE_HYP);
  endfunction

endpackage

// File: rtl/lut_access_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant from the request pair; the
// priority pointer moves to the non-winner whenever the owner strobes update.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // grant[0] set means requester 0 won, so requester 1 gets priority next.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/lut_access_arbiter.sv
// Shares one rotation-LUT port between the rotation and vectoring CORDIC
// engines: arbitrates, sequences the LUT handshake and returns the result.
module lut_access_arbiter
  import hcordic_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        mode0,
  input  logic [1:0]        mode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] kappa_out,
  output logic [DATA_W-1:0] theta_out,
  output logic [DATA_W-1:0] delta_out,
  output logic [1:0]        lut_mode,
  output logic [ADDR_W-1:0] lut_address,
  output logic              lut_enable,
  output logic              lut_operation,
  input  logic              lut_done,
  input  logic [DATA_W-1:0] lut_kappa,
  input  logic [DATA_W-1:0] lut_theta,
  input  logic [DATA_W-1:0] lut_delta
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lut_state_e state_reg, state_next;

  logic [1:0]        grant;
  logic              grant_valid;
  logic              take;
  logic              win_id;
  logic [1:0]        win_mode;
  logic [ADDR_W-1:0] win_addr;
  logic              win_mode_ok;
  logic              timeout_hit;

  logic              id_reg;
  logic              err_reg;
  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] kappa_reg;
  logic [DATA_W-1:0] theta_reg;
  logic [DATA_W-1:0] delta_reg;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({req1, req0}),
    .update  (take),
    .grant   (grant)
  );

  assign grant_valid = grant != 2'b00;
  assign win_id      = grant[1];
  assign win_mode    = win_id ? mode1 : mode0;
  assign win_addr    = win_id ? addr1 : addr0;
  assign win_mode_ok = mode_valid(win_mode);
  assign timeout_hit = cnt_reg == CNT_LAST;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake outputs are pure state decodes, so an asynchronous reset
  // forces them low in the same instant the state returns to IDLE.
  always_comb begin
    state_next    = state_reg;
    take          = 1'b0;
    lut_enable    = 1'b0;
    lut_operation = 1'b0;
    ack0          = 1'b0;
    ack1          = 1'b0;
    err           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          take       = 1'b1;
          state_next = win_mode_ok ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        lut_enable    = 1'b1;
        lut_operation = 1'b1;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        // Operation stays high so the LUT can retire its done flag.
        lut_operation = 1'b1;
        if (lut_done || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        ack0       = ~id_reg;
        ack1       = id_reg;
        err        = err_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_reg    <= 1'b0;
      err_reg   <= 1'b0;
      mode_reg  <= 2'b00;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      kappa_reg <= '0;
      theta_reg <= '0;
      delta_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            id_reg   <= win_id;
            mode_reg <= win_mode;
            addr_reg <= win_addr;
            err_reg  <= ~win_mode_ok;
          end
        end
        ST_ISSUE: begin
          cnt_reg <= '0;
        end
        ST_WAIT: begin
          // A done on the final wait cycle still wins over the timeout.
          if (lut_done) begin
            kappa_reg <= lut_kappa;
            theta_reg <= lut_theta;
            delta_reg <= lut_delta;
            err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lut_mode    = mode_reg;
  assign lut_address = addr_reg;
  assign kappa_out   = kappa_reg;
  assign theta_out   = theta_reg;
  assign delta_out   = delta_reg;

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Randomized self-checking bench for lut_access_arbiter with a transaction-level
// reference model (round-robin order, latency arithmetic, held response data).
module tb_lut_access_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  mode0 = 2'b00, mode1 = 2'b00;
  logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
  logic        ack0, ack1, err;
  logic [31:0] kappa_out, theta_out, delta_out;
  logic [1:0]  lut_mode;
  logic [7:0]  lut_address;
  logic        lut_enable, lut_operation;
  logic        lut_done;
  logic [31:0] lut_kappa, lut_theta, lut_delta;

  int checks = 0;
  int failures = 0;

  // LUT model controls: 0 = silent, N = done visible N cycles after enable.
  int         lut_lat = 1;
  int         lut_cd;
  logic [7:0] seen_addr;
  logic [1:0] seen_mode;
  int         en_cnt = 0;

  // Reference model state.
  int          m_prio = 0;
  logic [31:0] m_k = '0, m_t = '0, m_d = '0;

  lut_access_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(8), .DATA_W(32)) dut (
    .clock         (clk),
    .reset_n       (rst_n),
    .req0          (req0),
    .req1          (req1),
    .mode0         (mode0),
    .mode1         (mode1),
    .addr0         (addr0),
    .addr1         (addr1),
    .ack0          (ack0),
    .ack1          (ack1),
    .err           (err),
    .kappa_out     (kappa_out),
    .theta_out     (theta_out),
    .delta_out     (delta_out),
    .lut_mode      (lut_mode),
    .lut_address   (lut_address),
    .lut_enable    (lut_enable),
    .lut_operation (lut_operation),
    .lut_done      (lut_done),
    .lut_kappa     (lut_kappa),
    .lut_theta     (lut_theta),
    .lut_delta     (lut_delta)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] kap_f(input logic [7:0] a, input logic [1:0] m);
    return {8'hC0, 6'd0, m, a, ~a};
  endfunction

  function automatic logic [31:0] theta_f(input logic [7:0] a, input logic [1:0] m);
    if (a == 8'h10) return 32'h1234_5678;
    return {a, 8'h5A, ~a, 6'd0, m};
  endfunction

  function automatic logic [31:0] delta_f(input logic [7:0] a, input logic [1:0] m);
    return {16'hD00D, a ^ 8'h3C, 6'd0, m};
  endfunction

  assign lut_kappa = kap_f(seen_addr, seen_mode);
  assign lut_theta = theta_f(seen_addr, seen_mode);
  assign lut_delta = delta_f(seen_addr, seen_mode);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_done  <= 1'b0;
      lut_cd    <= 0;
      seen_addr <= 8'h00;
      seen_mode <= 2'b00;
    end else begin
      lut_done <= 1'b0;
      if (lut_enable) begin
        seen_addr <= lut_address;
        seen_mode <= lut_mode;
        if (lut_lat == 1) lut_done <= 1'b1;
        lut_cd <= (lut_lat > 1) ? lut_lat - 1 : 0;
      end else if (lut_cd != 0) begin
        lut_cd <= lut_cd - 1;
        if (lut_cd == 1) lut_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && lut_enable) en_cnt <= en_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one arbitration round from IDLE and checks every response against
  // the model. Returns at a negedge with the DUT back in IDLE.
  task automatic run_round(input bit r0, input bit r1,
                           input logic [1:0] m0, input logic [1:0] m1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input int lat, input string name);
    int cnt, t, got, n, budget, en_start, exp_en, p;
    int order[2];
    int e_port[2];
    int e_cyc[2];
    bit e_err[2];
    logic [31:0] e_k[2], e_t[2], e_d[2];
    logic [1:0] md;
    logic [7:0] ad;
    cnt = 0; t = 0; exp_en = 0;
    order[0] = 0; order[1] = 0;
    if (r0 && r1) begin
      order[0] = m_prio; order[1] = 1 - m_prio; cnt = 2;
    end else if (r0) begin
      order[0] = 0; cnt = 1;
    end else if (r1) begin
      order[0] = 1; cnt = 1;
    end
    for (int k = 0; k < cnt; k++) begin
      p  = order[k];
      md = (p == 1) ? m1 : m0;
      ad = (p == 1) ? a1 : a0;
      m_prio = 1 - p;
      // A second grant needs the RESP-to-IDLE cycle before sampling again.
      t = (k == 0) ? 0 : t + 1;
      if (md != 2'b01 && md != 2'b11) begin
        t += 1;
        e_err[k] = 1'b1;
      end else begin
        exp_en++;
        if (lat >= 1 && lat <= TIMEOUT) begin
          t += 2 + lat;
          e_err[k] = 1'b0;
          m_k = kap_f(ad, md); m_t = theta_f(ad, md); m_d = delta_f(ad, md);
        end else begin
          t += 2 + TIMEOUT;
          e_err[k] = 1'b1;
        end
      end
      e_port[k] = p; e_cyc[k] = t;
      e_k[k] = m_k; e_t[k] = m_t; e_d[k] = m_d;
    end

    en_start = en_cnt;
    lut_lat = lat;
    req0 = r0; mode0 = m0; addr0 = a0;
    req1 = r1; mode1 = m1; addr1 = a1;
    got = 0; n = 0;
    budget = 2 * (TIMEOUT + 4) + 4;
    while (got < cnt && n < budget) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        check_val({name, "_ack_onehot"}, 64'(ack0 & ack1), 64'd0);
        check_val({name, "_port"}, 64'(ack1), 64'(e_port[got]));
        check_val({name, "_cycle"}, 64'(n), 64'(e_cyc[got]));
        check_val({name, "_err"}, 64'(err), 64'(e_err[got]));
        check_val({name, "_kappa"}, 64'(kappa_out), 64'(e_k[got]));
        check_val({name, "_theta"}, 64'(theta_out), 64'(e_t[got]));
        check_val({name, "_delta"}, 64'(delta_out), 64'(e_d[got]));
        $display("%s: ack%0d cycle=%0d err=%0b theta=%08h", name, ack1 ? 1 : 0, n, err, theta_out);
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_val({name, "_ack_count"}, 64'(got), 64'(cnt));
    @(negedge clk);
    check_val({name, "_ack_pulse"}, 64'(ack0 | ack1), 64'd0);
    check_val({name, "_lut_en_count"}, 64'(en_cnt - en_start), 64'(exp_en));
  endtask

  logic [1:0] mtab [0:5];

  initial begin
    int first, second, n, sel, lat;
    bit r0, r1;
    mtab[0] = 2'b01; mtab[1] = 2'b11; mtab[2] = 2'b01;
    mtab[3] = 2'b11; mtab[4] = 2'b00; mtab[5] = 2'b10;

    // Reset state
    #1;
    check_val("rst_ack0", 64'(ack0), 64'd0);
    check_val("rst_ack1", 64'(ack1), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_data", {kappa_out, theta_out ^ delta_out}, 64'd0);
    check_val("rst_lut", {lut_mode, lut_address, lut_enable, lut_operation}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single circular request with an immediate LUT
    run_round(1, 0, 2'b01, 2'b00, 8'h10, 8'h00, 1, "single");
    check_val("single_lut_addr", 64'(seen_addr), 64'h10);
    check_val("single_lut_mode", 64'(seen_mode), 64'h1);

    // Simultaneous pair twice: priority alternates
    run_round(1, 1, 2'b11, 2'b11, 8'h21, 8'h31, 1, "pair_a");
    run_round(1, 1, 2'b11, 2'b11, 8'h22, 8'h32, 1, "pair_b");

    // Invalid mode
    run_round(0, 1, 2'b00, 2'b10, 8'h00, 8'h55, 1, "bad_mode");

    // Silent LUT, then a normal request
    run_round(1, 0, 2'b01, 2'b00, 8'h33, 8'h00, 0, "timeout");
    run_round(0, 1, 2'b00, 2'b11, 8'h00, 8'h34, 2, "after_to");

    // Done on the last permitted wait cycle
    run_round(1, 0, 2'b11, 2'b00, 8'h35, 8'h00, TIMEOUT, "edge_to");

    // Request held through its ack is served again
    req0 = 1'b1; mode0 = 2'b01; addr0 = 8'h44; lut_lat = 1;
    first = -1; second = -1; n = 0;
    while (second < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack0) begin
        if (first < 0) first = n; else second = n;
        check_val("held_err", 64'(err), 64'd0);
        check_val("held_theta", 64'(theta_out), 64'(theta_f(8'h44, 2'b01)));
      end
    end
    req0 = 1'b0;
    $display("held: ack0 cycles %0d and %0d", first, second);
    check_val("held_first", 64'(first), 64'd3);
    check_val("held_second", 64'(second), 64'd7);
    m_prio = 1;
    m_k = kap_f(8'h44, 2'b01); m_t = theta_f(8'h44, 2'b01); m_d = delta_f(8'h44, 2'b01);
    @(negedge clk);

    // Reset pulse during WAIT
    req0 = 1'b1; mode0 = 2'b11; addr0 = 8'h66; lut_lat = 0;
    repeat (4) @(negedge clk);
    check_val("rstw_op_in_wait", 64'(lut_operation), 64'd1);
    check_val("rstw_no_early_ack", 64'(ack0 | ack1), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstw_lut_ctl", {lut_enable, lut_operation}, 64'd0);
    check_val("rstw_lut_addr", {lut_mode, lut_address}, 64'd0);
    check_val("rstw_acks", {ack0, ack1, err}, 64'd0);
    check_val("rstw_data", {kappa_out, theta_out | delta_out}, 64'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_prio = 0; m_k = '0; m_t = '0; m_d = '0;
    repeat (3) begin
      @(negedge clk);
      check_val("rstw_no_ack_after", 64'(ack0 | ack1), 64'd0);
    end
    $display("reset_in_wait: released");
    run_round(1, 1, 2'b01, 2'b11, 8'h71, 8'h72, 1, "post_rst");

    // Randomized rounds
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) lat = 0;
      else if (sel == 1) lat = TIMEOUT + 1;
      else if (sel == 2) lat = TIMEOUT;
      else lat = $urandom_range(1, 4);
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_round(r0, r1, mtab[$urandom_range(0, 5)], mtab[$urandom_range(0, 5)],
                8'($urandom), 8'($urandom), lat, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
